// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device clock
// falls, ACK check and watchdog. Outputs are open-collector pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned SETUP_US   = 1,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CYC_PER_US  = CLK_FREQ / 1000000;
  localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int unsigned SETUP_CYC   = CYC_PER_US * SETUP_US;
  localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int unsigned MAX_CYC     = (TIMEOUT_CYC > INHIBIT_CYC) ?
                                        ((TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC) :
                                        ((INHIBIT_CYC > SETUP_CYC) ? INHIBIT_CYC : SETUP_CYC);
  localparam int unsigned TW          = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_SETUP, S_SEND, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [7:0]      r_byte, w_byte_nxt;
  logic            r_parity, w_parity_nxt;
  logic [3:0]      r_nedge, w_nedge_nxt;
  logic            r_ack, w_ack_nxt;
  logic            r_clk_oe, w_clk_oe_nxt;
  logic            r_data_oe, w_data_oe_nxt;
  logic            r_ready, r_done, r_err;
  logic            w_done_nxt, w_err_nxt;
  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  logic            w_fall, w_timeout;

  assign w_fall    = ~r_clk_s2 & r_clk_prev;
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYC - 1));

  assign tx_ready    = r_ready;
  assign tx_done     = r_done;
  assign tx_err      = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  // Timer is shared: inhibit/setup delay, then the watchdog across SEND and WAIT_IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + 1'b1;
    w_byte_nxt    = r_byte;
    w_parity_nxt  = r_parity;
    w_nedge_nxt   = r_nedge;
    w_ack_nxt     = r_ack;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (tx_valid) begin
          w_byte_nxt    = tx_data;
          w_parity_nxt  = ~^tx_data;
          w_nedge_nxt   = '0;
          w_state_nxt   = S_INHIBIT;
          w_clk_oe_nxt  = 1'b1;
          w_data_oe_nxt = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (r_timer == TW'(INHIBIT_CYC - 1)) begin
          w_state_nxt   = S_SETUP;
          w_timer_nxt   = '0;
          w_data_oe_nxt = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_timer == TW'(SETUP_CYC - 1)) begin
          w_state_nxt  = S_SEND;
          w_timer_nxt  = '0;
          w_clk_oe_nxt = 1'b0;
        end
      end
      S_SEND: begin
        if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
        end else if (w_fall) begin
          w_nedge_nxt = r_nedge + 4'd1;
          if (r_nedge < 4'd8) begin
            w_data_oe_nxt = ~r_byte[r_nedge[2:0]];
          end else if (r_nedge == 4'd8) begin
            w_data_oe_nxt = ~r_parity;
          end else if (r_nedge == 4'd9) begin
            w_data_oe_nxt = 1'b0;
          end else begin
            w_ack_nxt     = ~r_dat_s2;
            w_state_nxt   = S_WAIT_IDLE;
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_timeout) begin
          w_state_nxt   = S_DONE;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
          w_done_nxt    = 1'b1;
          w_err_nxt     = 1'b1;
        end else if (r_clk_s2 && r_dat_s2) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = ~r_ack;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_nedge    <= '0;
      r_ack      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_byte     <= w_byte_nxt;
      r_parity   <= w_parity_nxt;
      r_nedge    <= w_nedge_nxt;
      r_ack      <= w_ack_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_ready    <= (w_state_nxt == S_IDLE);
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_clk_s1   <= ps2_clk_i;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data_i;
      r_dat_s2   <= r_dat_s1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND bus and a clocking PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  assign ps2_clk_line  = ~ps2_clk_oe & ~dev_clk_low;
  assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

  ps2_host_tx #(
    .CLK_FREQ  (1000000),
    .INHIBIT_US(100),
    .SETUP_US  (1),
    .TIMEOUT_US(15000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_i  (ps2_clk_line),
    .ps2_data_i (ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #500 clk = ~clk;

  always @(posedge clk) if (tx_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents the byte for one cycle; returns at the negedge of cycle T+1.
  task automatic start_send(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Called at cycle T+1; returns at SEND entry with clock released, start bit held.
  task automatic preamble(input string tag);
    int bad = 0;
    check({tag, ".ready_low"}, {31'd0, tx_ready}, 32'd0);
    for (int k = 1; k <= 100; k++) begin
      if (!(ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0)) bad++;
      @(negedge clk);
    end
    check({tag, ".inhibit"}, bad, 32'd0);
    check({tag, ".setup"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h3);
    @(negedge clk);
    check({tag, ".send"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h1);
  endtask

  // Device: samples start before clocking, then samples on each rise after falls 1..10.
  task automatic dev_frame(input bit give_ack, input int nfalls, output logic [10:0] rx);
    rx = '0;
    #20000;
    rx[0] = ps2_data_line;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      #20000;
      dev_clk_low = 1'b0;
      if (i <= 10) rx[i] = ps2_data_line;
      if (i == 11) dev_data_low = 1'b0;
      if (i < nfalls) begin
        if (i == 10 && give_ack) begin
          #5000;
          dev_data_low = 1'b1;
          #15000;
        end else begin
          #20000;
        end
      end
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, ".err"}, {31'd0, tx_err}, {31'd0, exp_err});
    check({tag, ".oe_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk);
    check({tag, ".ready_back"}, {30'd0, tx_ready, tx_done}, 32'h2);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input logic [10:0] exp_rx);
    logic [10:0] rx;
    start_send(b);
    preamble(tag);
    dev_frame(1'b1, 11, rx);
    check({tag, ".rx"}, {21'd0, rx}, {21'd0, exp_rx});
    wait_done(tag, 1'b0);
  endtask

  initial begin
    logic [10:0] rx;
    int d0;

    repeat (3) @(negedge clk);
    check("reset.outs", {27'd0, tx_ready, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'h10);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // frame words are {stop, parity, byte, start}
    run_frame("f_ED", 8'hED, 11'h7DA);
    run_frame("f_00", 8'h00, 11'h600);
    run_frame("f_01", 8'h01, 11'h402);
    run_frame("f_FF", 8'hFF, 11'h7FE);

    start_send(8'h81);
    preamble("noack");
    dev_frame(1'b0, 11, rx);
    check("noack.rx", {21'd0, rx}, 32'h702);
    wait_done("noack", 1'b1);

    start_send(8'hED);
    preamble("tmo");
    repeat (14999) @(negedge clk);
    check("tmo.before", {29'd0, tx_done, ps2_clk_oe, ps2_data_oe}, 32'h1);
    @(negedge clk);
    check("tmo.at", {28'd0, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'hC);
    @(negedge clk);
    check("tmo.ready", {31'd0, tx_ready}, 32'd1);

    start_send(8'hED);
    preamble("rst");
    dev_frame(1'b0, 5, rx);
    repeat (4) @(negedge clk);
    check("rst.bit4", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'h1);
    d0 = done_cnt;
    #100;
    reset_n = 1'b0;
    #1;
    check("rst.async", {29'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 32'h4);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst.no_done", done_cnt - d0, 32'd0);
    run_frame("f_F4", 8'hF4, 11'h5E8);

    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    tx_data  = 8'hAA;
    preamble("hold");
    dev_frame(1'b1, 11, rx);
    check("hold.rx", {21'd0, rx}, 32'h6B4);
    wait_done("hold", 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    preamble("hold2");
    dev_frame(1'b1, 11, rx);
    check("hold2.rx", {21'd0, rx}, 32'h754);
    wait_done("hold2", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
